fuel_gauge_ctrl: RTL and testbench
==================================

# fuel_gauge_ctrl

Clocked, parametrised successor to the combinational fuel-gauge bar decoder. It samples the raw fuel level on a strobe and smooths it with a power-of-two moving average. The smoothed level is mapped to a bar of lit segments; at or below a low threshold the bar blinks and a warning flag is raised. It sits between the fuel-sensor sampling logic and the 7-segment bar display, and keeps the battery-mode override.

## Interface
- LVL_W, 4: width of raw fuel level.
- SEGS, 7: number of bar segments (bit SEGS-1 = segment a, bit 0 = g).
- STEP, 2: level units per bar segment.
- AVG_LOG2, 2: log2 of averaging window depth (window = 2^AVG_LOG2 samples).
- LOW_BARS, 1: bar count at or below which low-fuel warning is active.
- BLINK_HALF, 25000000: blink half-period in clock cycles (≥1).

- Clk_in, input, 1: system clock, rising edge.
- Rst_in, input, 1: reset, asynchronous, active-high.
- FLvl_in, input, LVL_W: raw fuel level, sampled only when Sample_in=1.
- Sample_in, input, 1: one-cycle sample strobe.
- BMode_in, input, 1: battery-mode override.
- FGauge_out, output, SEGS: registered segment drive, active-high.
- LowFuel_out, output, 1: registered low-fuel warning.
- Valid_out, output, 1: registered; 1 once at least one sample has been taken since reset.

## Operation
- **States:** EMPTY (after reset) and RUN.
  - EMPTY→RUN on the first Sample_in=1.
  - No other transitions; only Rst_in returns the block to EMPTY.
- **Averager, priming:** the first sample writes FLvl_in into all 2^AVG_LOG2 window entries and sets sum = FLvl_in << AVG_LOG2.
- **Averager, later samples:** sum ← sum + FLvl_in − oldest. The new value overwrites the oldest entry and the write pointer wraps modulo the window depth.
- **Averager, arithmetic:**
  - sum is LVL_W+AVG_LOG2 bits and never overflows.
  - avg = sum >> AVG_LOG2, truncated.
- **Bar mapping:** n = min(SEGS, ceil(avg/STEP)). Bar pattern lights the top n bits (bits SEGS-1 down to SEGS-n).
- **Low-fuel condition:** low = RUN && !BMode_in && n ≤ LOW_BARS.
- **Blink generator:**
  - Counter plus phase bit, phase initially ON.
  - While low: the counter counts to BLINK_HALF-1, then wraps to 0 and toggles the phase.
  - While not low: counter=0, phase=ON. Re-entry therefore always starts in the ON phase.
- **Output priority (highest first):**
  - EMPTY: FGauge_out=0, LowFuel_out=0, Valid_out=0.
  - BMode_in=1: FGauge_out = only bit 0 set (segment g), LowFuel_out=0. Averaging continues underneath.
  - low: LowFuel_out=1. In ON phase FGauge_out = bar pattern, or segment a alone if n=0. In OFF phase FGauge_out = 0.
  - otherwise: FGauge_out = bar pattern, LowFuel_out=0.
- **Simultaneous Sample_in and BMode_in:** the sample is still accepted.

## Timing
- **Reset values:** every output is 0; window entries, sum and pointer are 0; state is EMPTY; blink counter is 0 with phase ON. Async assertion clears all of these immediately, including mid-blink or mid-window.
- **Sample latency:** Sample_in sampled at edge E updates the window and sum at E. FGauge_out, LowFuel_out and Valid_out reflect it at edge E+1.
- **BMode_in latency:** a change appears on the outputs at the next edge.
- **Blink timing:** a change of low condition is visible after 1 edge. Each phase then lasts exactly BLINK_HALF cycles.
- **Sample rate:** back-to-back strobes (one per cycle) are legal and each one is accepted.

## Structure
- **Package fuel_gauge_pkg:**
  - state enum (EMPTY, RUN);
  - function bar_pattern(n) parametrised on SEGS;
  - constant SEG_A_ONLY;
  - constant SEG_G_ONLY.
- **Sub-module fuel_avg:** window memory, pointer, running sum, priming. Parameters LVL_W and AVG_LOG2. Outputs avg and a primed flag.
- **Top:** the top level holds the state, the bar mapping, the blink generator and the output register.

## Test plan
All scenarios use default parameters except BLINK_HALF=4.
- **Reset and first sample:** after reset, check outputs = 0. Then apply Sample_in with FLvl_in=15 → one edge later FGauge_out=1111111, Valid_out=1, LowFuel_out=0.
- **Averaging:** prime with 8 (1111000), then samples 0, 0, 0, 0 → avg 6, 4, 2, 0 → FGauge_out 1110000, 1100000, then low-fuel blink.
- **Low-fuel blink:** prime with 2 → LowFuel_out=1 and FGauge_out alternates 1000000 / 0000000, each held 4 cycles. Prime with 0 instead → segment a blinks the same way.
- **Battery-mode override:** assert BMode_in during the OFF phase → next edge FGauge_out=0000001, LowFuel_out=0. Deassert → blink resumes in ON phase with 1000000 held 4 cycles.
- **Sample during battery mode:** with BMode_in=1 and primed at 15, sample 0 four times, then release BMode_in → blink at n=0 (segment a).
- **Async reset mid-operation:** assert Rst_in mid-blink and mid-window → outputs 0 immediately. A new first sample of 15 gives 1111111, with no residue from the old window.

Source files
------------

// File: rtl/fuel_gauge_pkg.sv
// Shared types and helpers for the fuel gauge: controller state, bar-pattern builder, fixed segment codes.
// Segment bit SEGS-1 is segment a (top of the bar), bit 0 is segment g.
package fuel_gauge_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int SEGS_MAX = 32;

    // Battery-mode indication: segment g alone.
    localparam logic [SEGS_MAX-1:0] SEG_G_ONLY = 32'h0000_0001;

    // A bar of this length lights segment a alone.
    localparam int SEG_A_ONLY = 1;

    // Lights the top n of segs bits; callers size-cast the result to their SEGS width.
    function automatic logic [SEGS_MAX-1:0] bar_pattern(input int segs, input int n);
        logic [SEGS_MAX-1:0] p;
        p = '0;
        for (int i = 0; i < SEGS_MAX; i++) begin
            p[i] = (i < segs) && (i >= segs - n);
        end
        return p;
    endfunction

endpackage

// File: rtl/fuel_avg.sv
// Power-of-two moving average over the last 2^AVG_LOG2 strobed fuel samples.
// The first sample primes every window entry so the average is meaningful immediately.
module fuel_avg #(
    parameter int LVL_W    = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_i,
    input  logic [LVL_W-1:0] lvl_i,
    output logic [LVL_W-1:0] avg_o,
    output logic             primed_o
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = LVL_W + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [LVL_W-1:0] win_q [DEPTH];
    logic [LVL_W-1:0] win_d [DEPTH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             primed_q, primed_d;

    always_comb begin
        win_d    = win_q;
        sum_d    = sum_q;
        ptr_d    = ptr_q;
        primed_d = primed_q;
        if (sample_i) begin
            if (!primed_q) begin
                for (int i = 0; i < DEPTH; i++) begin
                    win_d[i] = lvl_i;
                end
                sum_d    = SUM_W'(lvl_i) << AVG_LOG2;
                ptr_d    = '0;
                primed_d = 1'b1;
            end else begin
                // Modular arithmetic is exact: the true sum always fits in SUM_W bits.
                win_d[ptr_q] = lvl_i;
                sum_d        = sum_q + SUM_W'(lvl_i) - SUM_W'(win_q[ptr_q]);
                ptr_d        = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q    <= '0;
            ptr_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            sum_q    <= sum_d;
            ptr_q    <= ptr_d;
            primed_q <= primed_d;
        end
    end

    assign avg_o    = LVL_W'(sum_q >> AVG_LOG2);
    assign primed_o = primed_q;

endmodule

// File: rtl/fuel_gauge_ctrl.sv
// Smoothed fuel level to a registered 7-segment bar, with low-fuel blink and battery-mode override.
// Outputs reflect a sample one edge after it is strobed; every output is a flop.
module fuel_gauge_ctrl
    import fuel_gauge_pkg::*;
#(
    parameter int LVL_W      = 4,
    parameter int SEGS       = 7,
    parameter int STEP       = 2,
    parameter int AVG_LOG2   = 2,
    parameter int LOW_BARS   = 1,
    parameter int BLINK_HALF = 25000000
) (
    input  logic             Clk_in,
    input  logic             Rst_in,
    input  logic [LVL_W-1:0] FLvl_in,
    input  logic             Sample_in,
    input  logic             BMode_in,
    output logic [SEGS-1:0]  FGauge_out,
    output logic             LowFuel_out,
    output logic             Valid_out
);

    localparam int NW    = $clog2(SEGS + 1);
    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SEGS-1:0] SEG_A_PAT = SEGS'(bar_pattern(SEGS, SEG_A_ONLY));
    localparam logic [SEGS-1:0] SEG_G_PAT = SEGS'(SEG_G_ONLY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_off_q, phase_off_d;
    logic [SEGS-1:0]  fgauge_q, fgauge_d;
    logic             lowfuel_q, lowfuel_d;
    logic             valid_q, valid_d;

    logic [LVL_W-1:0] avg;
    logic             primed;
    int               n_full;
    logic [NW-1:0]    n;
    logic [SEGS-1:0]  bar;
    logic             run;
    logic             low;

    fuel_avg #(
        .LVL_W    (LVL_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk_i    (Clk_in),
        .rst_i    (Rst_in),
        .sample_i (Sample_in),
        .lvl_i    (FLvl_in),
        .avg_o    (avg),
        .primed_o (primed)
    );

    // Bar length is ceil(avg / STEP), clipped to the number of segments.
    always_comb begin
        n_full = (int'(avg) + STEP - 1) / STEP;
        n      = (n_full > SEGS) ? NW'(SEGS) : NW'(n_full);
        bar    = SEGS'(bar_pattern(SEGS, int'(n)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        phase_off_d = 1'b0;
        fgauge_d    = '0;
        lowfuel_d   = 1'b0;
        valid_d     = 1'b0;

        if (state_q == EMPTY && Sample_in) begin
            state_d = RUN;
        end

        run = (state_q == RUN) && primed;
        low = run && !BMode_in && (int'(n) <= LOW_BARS);

        // Leaving low parks the blinker in the ON phase so re-entry always starts lit.
        if (low) begin
            if (cnt_q == CNT_W'(BLINK_HALF - 1)) begin
                phase_off_d = !phase_off_q;
            end else begin
                cnt_d       = cnt_q + CNT_W'(1);
                phase_off_d = phase_off_q;
            end
        end

        if (run) begin
            valid_d = 1'b1;
            if (BMode_in) begin
                fgauge_d = SEG_G_PAT;
            end else if (low) begin
                lowfuel_d = 1'b1;
                if (!phase_off_q) begin
                    fgauge_d = (n == '0) ? SEG_A_PAT : bar;
                end
            end else begin
                fgauge_d = bar;
            end
        end
    end

    always_ff @(posedge Clk_in or posedge Rst_in) begin
        if (Rst_in) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            phase_off_q <= 1'b0;
            fgauge_q    <= '0;
            lowfuel_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_off_q <= phase_off_d;
            fgauge_q    <= fgauge_d;
            lowfuel_q   <= lowfuel_d;
            valid_q     <= valid_d;
        end
    end

    assign FGauge_out  = fgauge_q;
    assign LowFuel_out = lowfuel_q;
    assign Valid_out   = valid_q;

endmodule

// File: tb/tb_fuel_gauge_ctrl.sv
// Bench for fuel_gauge_ctrl with BLINK_HALF=4: directed vector table, async-reset sequence, randomized run vs model.
module tb_fuel_gauge_ctrl;

    localparam int BH = 4;

    logic       Clk_in;
    logic       Rst_in;
    logic [3:0] FLvl_in;
    logic       Sample_in;
    logic       BMode_in;
    logic [6:0] FGauge_out;
    logic       LowFuel_out;
    logic       Valid_out;

    fuel_gauge_ctrl #(
        .LVL_W      (4),
        .SEGS       (7),
        .STEP       (2),
        .AVG_LOG2   (2),
        .LOW_BARS   (1),
        .BLINK_HALF (BH)
    ) dut (
        .Clk_in      (Clk_in),
        .Rst_in      (Rst_in),
        .FLvl_in     (FLvl_in),
        .Sample_in   (Sample_in),
        .BMode_in    (BMode_in),
        .FGauge_out  (FGauge_out),
        .LowFuel_out (LowFuel_out),
        .Valid_out   (Valid_out)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    // Reference model: sample history as a queue, blink phase from how long low has persisted.
    int win[$];
    int low_run;
    int m_fg;
    bit m_low;
    bit m_vld;

    function automatic int bar_of(input int n);
        return ((1 << n) - 1) << (7 - n);
    endfunction

    task automatic model_predict(input bit b);
        int sum, avg, n;
        m_fg = 0; m_low = 0; m_vld = 0;
        if (win.size() != 0) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            avg = sum / 4;
            n   = (avg + 1) / 2;
            if (n > 7) n = 7;
            m_vld = 1;
            if (b) begin
                m_fg = 1;
            end else if (n <= 1) begin
                m_low = 1;
                if (((low_run / BH) % 2) == 0) m_fg = (n == 0) ? 64 : bar_of(n);
            end else begin
                m_fg = bar_of(n);
            end
        end
    endtask

    task automatic model_update(input bit s, input int l);
        low_run = m_low ? low_run + 1 : 0;
        if (s) begin
            if (win.size() == 0) begin
                for (int i = 0; i < 4; i++) win.push_back(l);
            end else begin
                void'(win.pop_front());
                win.push_back(l);
            end
        end
    endtask

    task automatic apply_edge(input bit s, input logic [3:0] l, input bit b);
        @(negedge Clk_in);
        Sample_in = s; FLvl_in = l; BMode_in = b;
        model_predict(b);
        @(posedge Clk_in);
        model_update(s, int'(l));
        #1;
    endtask

    task automatic rst_on();
        @(negedge Clk_in);
        #1;
        Rst_in = 1'b1; Sample_in = 1'b0; BMode_in = 1'b0;
        win.delete();
        low_run = 0;
        #1;
    endtask

    task automatic rst_off();
        Rst_in = 1'b0;
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         s;
        logic [3:0] l;
        bit         b;
        logic [6:0] fg;
        bit         low;
        bit         vld;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rst, input bit s, input logic [3:0] l, input bit b,
                                input logic [6:0] fg, input bit low, input bit vld);
        vec_t v;
        v.rst = rst; v.s = s; v.l = l; v.b = b; v.fg = fg; v.low = low; v.vld = vld;
        return v;
    endfunction

    initial begin
        Rst_in = 1'b0; Sample_in = 1'b0; FLvl_in = '0; BMode_in = 1'b0;
        low_run = 0;

        // Reset, first sample 15
        tbl.push_back(mk(1, 0, 0,  0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 15, 0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 7'b1111111, 0, 1));
        // Averaging 8 then four zeros, into blink at n=1 then n=0
        tbl.push_back(mk(1, 0, 0,  0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 7'b1111000, 0, 1));
        tbl.push_back(mk(0, 1, 0,  0, 7'b1110000, 0, 1));
        tbl.push_back(mk(0, 1, 0,  0, 7'b1100000, 0, 1));
        tbl.push_back(mk(0, 1, 0,  0, 7'b1000000, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b0000000, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 1));
        // Battery mode asserted during OFF phase, then released
        tbl.push_back(mk(0, 0, 0,  0, 7'b0000000, 1, 1));
        tbl.push_back(mk(0, 0, 0,  1, 7'b0000001, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 7'b0000000, 1, 1));
        // Samples accepted under battery mode
        tbl.push_back(mk(1, 0, 0,  0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 15, 1, 7'b0000000, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 1, 7'b0000001, 0, 1));
        tbl.push_back(mk(0, 0, 0,  1, 7'b0000001, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 7'b1000000, 1, 1));
        // Prime with 2: blink of segment a at n=1
        tbl.push_back(mk(1, 0, 0,  0, 7'b0000000, 0, 0));
        tbl.push_back(mk(0, 1, 2,  0, 7'b0000000, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b1000000, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 7'b0000000, 1, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].rst) begin
                rst_on();
            end else begin
                apply_edge(tbl[k].s, tbl[k].l, tbl[k].b);
            end
            chk($sformatf("vec%0d.fgauge", k), 32'(FGauge_out),  32'(tbl[k].fg));
            chk($sformatf("vec%0d.lowfuel", k), 32'(LowFuel_out), 32'(tbl[k].low));
            chk($sformatf("vec%0d.valid", k),  32'(Valid_out),   32'(tbl[k].vld));
            if (tbl[k].rst) rst_off();
        end

        // Async reset mid-window and mid-blink, then clean restart
        apply_edge(1, 2, 0);
        apply_edge(1, 0, 0);
        apply_edge(0, 0, 0);
        apply_edge(0, 0, 0);
        apply_edge(0, 0, 0);
        rst_on();
        chk("arst.fgauge",  32'(FGauge_out),  32'h0);
        chk("arst.lowfuel", 32'(LowFuel_out), 32'h0);
        chk("arst.valid",   32'(Valid_out),   32'h0);
        rst_off();
        apply_edge(1, 15, 0);
        chk("arst.pre_sample", 32'(Valid_out), 32'h0);
        apply_edge(1, 0, 0);
        chk("arst.restart_fg",  32'(FGauge_out), 32'h7f);
        chk("arst.restart_vld", 32'(Valid_out),  32'h1);
        apply_edge(0, 0, 0);
        chk("arst.window_fg", 32'(FGauge_out), 32'h7e);

        // Randomized run against the model
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_on();
                chk("rand.rst_fg", 32'(FGauge_out), 32'h0);
                rst_off();
            end
            apply_edge($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 9) == 0);
            chk($sformatf("rand%0d.fgauge", it),  32'(FGauge_out),  32'(m_fg));
            chk($sformatf("rand%0d.lowfuel", it), 32'(LowFuel_out), 32'(m_low));
            chk($sformatf("rand%0d.valid", it),   32'(Valid_out),   32'(m_vld));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
